vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port 8bpp framebuffer RAM between display fetch and two write
//  requesters (0 = graphics engine, 1 = CPU). Display fetch has absolute priority.
//  The framebuffer is 320x240, pixel-doubled to 640x480. hc_in/vc_in come from the
//  vga timing generator. pix_rgb (3-3-2) feeds its colour inputs, aligned to the current hc_in.
// PARAMETERS
//  FB_W      320  framebuffer width (pixels)
//  FB_H      240  framebuffer height (lines)
//  ADDR_W    17   RAM address width; FB_W*FB_H must be <= 2**ADDR_W
//  H_ACTIVE  640  visible pixels per line
//  H_TOTAL   800  clocks per line
//  V_ACTIVE  480  visible lines per frame
//  V_TOTAL   525  lines per frame
// PORTS
//  vgaclk      in   1       25 MHz pixel clock
//  rst         in   1       synchronous, active-high reset
//  hc_in       in   10      horizontal counter from timing generator (0..H_TOTAL-1)
//  vc_in       in   10      vertical counter from timing generator (0..V_TOTAL-1)
//  pix_rgb     out  8       {r[2:0],g[2:0],b[1:0]} for pixel (hc_in,vc_in)
//  wr_valid    in   2       per-requester write request
//  wr_addr     in   2x17    per-requester word address (y*FB_W + x)
//  wr_data     in   2x8     per-requester pixel data
//  wr_ready    out  2       per-requester accept; write done when valid&&ready
//  ram_addr    out  ADDR_W  RAM address
//  ram_we      out  1       RAM write enable
//  ram_wdata   out  8       RAM write data
//  ram_rdata   in   8       RAM read data, valid the cycle after the read address
//  frame_start out  1       1-cycle pulse when hc_in==0 && vc_in==0
// BEHAVIOUR
//  - Lookahead position (hl,vl) = (hc_in,vc_in) advanced 2 clocks.
//    hl wraps at H_TOTAL; vl increments on the hl wrap and wraps at V_TOTAL.
//  - Display slot: a cycle with hl even, hl<H_ACTIVE, vl<V_ACTIVE. In that cycle:
//    ram_we=0, ram_addr=(vl>>1)*FB_W+(hl>>1), wr_ready=2'b00.
//  - Fetch pipeline: addr at cycle t; ram_rdata sampled at end of t+1 into pix_reg;
//    pix_reg drives pix_rgb in t+2 and t+3 (pixels hl, hl+1).
//    The pixel-register load is tagged with the lookahead visibility. If the fetch
//    was not a display slot, pix_reg loads 0 instead of ram_rdata.
//  - Non-display cycles (odd-hl active cycles and all blanking) are write slots.
//    Grant goes to one valid requester. If both are valid, the grant follows the rr
//    pointer, and the pointer then moves to the other requester. A single valid
//    requester is granted without moving the pointer.
//  - wr_ready is combinational. It is 1 only for the granted requester in a write
//    slot, never for both.
//  - Granted write: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, same cycle.
//    Address >= FB_W*FB_H: accepted (ready=1), ram_we=0, no RAM access.
//  - Idle write slot: ram_we=0, ram_addr=0.
//  - Write bandwidth: >=1 slot every 2 clocks during active video, every clock in
//    blanking. Worst-case wait for a lone requester is 1 cycle; under contention it is 3 cycles.
//  - Read/write same address: a write in an odd slot is visible to any later fetch.
//    There is no bypass of an already-fetched pix_reg.
//  - Reset: pix_reg=0, rr pointer=requester 0, wr_ready=0, ram_we=0, ram_addr=0,
//    frame_start=0. In-flight fetch is discarded; pix_rgb=0 until the first post-reset display fetch.
//  - All arithmetic is unsigned. The (vl>>1)*FB_W product is computed at ADDR_W bits
//    and never truncates for legal vl.
// TESTING
//  1 Fill RAM with addr[7:0]; run one frame; (hc,vc)=(0,0)->pix 0x00, (2,0)->0x01, (639,479)->(239*320+319)[7:0].
//  2 Requester 0 holds wr_valid during active video -> ready only on odd-hl cycles, 1 write per 2 clocks.
//  3 Both requesters valid for 6 blanking cycles -> grants 0,1,0,1,0,1, never simultaneous.
//  4 Write 0xE3 to addr 0 during vblank -> next frame (0,0) and (1,0) show 0xE3, all blanking pix 0x00.
//  5 Write to addr 76800 -> wr_ready=1, ram_we stays 0, RAM contents unchanged.
//  6 Assert rst at hc=300,vc=100 for 1 cycle -> outputs 0 next cycle, rr=0, correct pixels next line.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Write-requester and framebuffer-RAM bus around vram_arbiter.
// The arbiter takes the slave side; requesters and the RAM sit on the master side.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [1:0]             wr_valid;
    logic [1:0][ADDR_W-1:0] wr_addr;
    logic [1:0][7:0]        wr_data;
    logic [1:0]             wr_ready;
    logic [ADDR_W-1:0]      ram_addr;
    logic                   ram_we;
    logic [7:0]             ram_wdata;
    logic [7:0]             ram_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, ram_rdata,
        output wr_ready, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, ram_rdata,
        input  wr_ready, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: pixel-doubled display fetch has absolute priority,
// and the remaining cycles are shared round-robin between two write requesters.
module vram_arbiter #(
    parameter int unsigned FB_W     = 320,
    parameter int unsigned FB_H     = 240,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic         vgaclk,
    input  logic         rst,
    input  logic [9:0]   hc_in,
    input  logic [9:0]   vc_in,
    output logic [7:0]   pix_rgb,
    vram_arbiter_if.slave bus,
    output logic         frame_start
);
    typedef enum logic {RR_REQ0 = 1'b0, RR_REQ1 = 1'b1} rr_t;

    rr_t               r_rr;
    logic [7:0]        r_pix;
    logic              r_tag_even;
    logic              r_tag_vis;

    logic [10:0]       w_hsum;
    logic              w_hwrap;
    logic [9:0]        w_hl;
    logic [9:0]        w_vl;
    logic              w_disp;
    logic              w_slot;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [1:0]        w_gnt;
    logic              w_gsel;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;
    logic              w_in_range;

    // Position two clocks ahead: one cycle of RAM latency plus one into pix_reg.
    always_comb begin
        w_hsum  = {1'b0, hc_in} + 11'd2;
        w_hwrap = (w_hsum >= 11'(H_TOTAL));
        w_hl    = w_hwrap ? 10'(w_hsum - 11'(H_TOTAL)) : w_hsum[9:0];
        w_vl    = vc_in;
        if (w_hwrap) begin
            w_vl = (vc_in == 10'(V_TOTAL - 1)) ? '0 : vc_in + 10'd1;
        end
    end

    assign w_disp       = !w_hl[0] && (w_hl < 10'(H_ACTIVE)) && (w_vl < 10'(V_ACTIVE));
    assign w_fetch_addr = ADDR_W'(w_vl >> 1) * ADDR_W'(FB_W) + ADDR_W'(w_hl >> 1);
    assign w_slot       = !rst && !w_disp;

    always_comb begin
        w_gnt = 2'b00;
        if (w_slot) begin
            case (bus.wr_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_rr == RR_REQ1) ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_gsel     = w_gnt[1];
    assign w_waddr    = bus.wr_addr[w_gsel];
    assign w_wdata    = bus.wr_data[w_gsel];
    assign w_in_range = ({1'b0, w_waddr} < (ADDR_W + 1)'(FB_W * FB_H));

    assign bus.wr_ready = w_gnt;

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (!rst && w_disp) begin
            bus.ram_addr = w_fetch_addr;
        end else if (w_gnt != 2'b00) begin
            bus.ram_addr  = w_waddr;
            bus.ram_we    = w_in_range;
            bus.ram_wdata = w_wdata;
        end
    end

    assign frame_start = !rst && (hc_in == '0) && (vc_in == '0);
    assign pix_rgb     = r_pix;

    // Every even-lookahead cycle is a fetch; its visibility tag decides RAM data or black.
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_pix      <= '0;
            r_rr       <= RR_REQ0;
            r_tag_even <= 1'b0;
            r_tag_vis  <= 1'b0;
        end else begin
            r_tag_even <= !w_hl[0];
            r_tag_vis  <= w_disp;
            if (r_tag_even) begin
                r_pix <= r_tag_vis ? bus.ram_rdata : '0;
            end
            if (w_slot && (bus.wr_valid == 2'b11)) begin
                r_rr <= (r_rr == RR_REQ0) ? RR_REQ1 : RR_REQ0;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a frame-position reference model queues expected
// per-cycle outputs, and a negedge monitor pops and compares them.
module tb_vram_arbiter;
    localparam int unsigned ADDR_W  = 17;
    localparam int          FB_SIZE = 76800;

    typedef struct {
        logic [7:0]        pix;
        logic [1:0]        rdy;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic              fs;
        bit                chk_pix;
        bit                pristine;
        bit                t4;
        int                hc;
        int                vc;
    } exp_t;

    logic       vgaclk = 1'b0;
    logic       rst    = 1'b1;
    logic [9:0] hc_in  = '0;
    logic [9:0] vc_in  = '0;
    logic [7:0] pix_rgb;
    logic       frame_start;

    vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    vram_arbiter #(
        .FB_W(320), .FB_H(240), .ADDR_W(ADDR_W),
        .H_ACTIVE(640), .H_TOTAL(800), .V_ACTIVE(480), .V_TOTAL(525)
    ) dut (
        .vgaclk      (vgaclk),
        .rst         (rst),
        .hc_in       (hc_in),
        .vc_in       (vc_in),
        .pix_rgb     (pix_rgb),
        .bus         (bus),
        .frame_start (frame_start)
    );

    always #20 vgaclk = ~vgaclk;

    // Framebuffer RAM: filled with addr[7:0] on the first edge, read data one cycle late.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    bit         ram_filled = 1'b0;
    always @(posedge vgaclk) begin
        if (!ram_filled) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 8'(i);
            ram_filled <= 1'b1;
        end else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    logic [7:0] shadow [0:FB_SIZE-1];
    int         turn;
    logic [7:0] cur;
    bit         fv   [2];
    logic [7:0] fval [2];
    int         nh, nv;
    bit         pristine, t4, chk_pix_en;
    exp_t       q [$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int base = ((nv / 2) % 240) * 320 + ((nh / 2) % 320);
        case ($urandom_range(0, 3))
            0:       return ADDR_W'(FB_SIZE + int'($urandom_range(0, 99)));
            1:       return ADDR_W'($urandom_range(0, FB_SIZE - 1));
            default: return ADDR_W'((base + int'($urandom_range(0, 3))) % FB_SIZE);
        endcase
    endfunction

    // One clock: apply inputs at position (nh,nv), predict every output, then advance.
    task automatic drive_cycle(input bit r, input logic [1:0] v,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
        int         pos, hl, vl, wa;
        bit         disp;
        logic [1:0] g;
        exp_t       e;
        @(posedge vgaclk);
        #1;
        rst            = r;
        hc_in          = 10'(nh);
        vc_in          = 10'(nv);
        bus.wr_valid   = v;
        bus.wr_addr[0] = a0;
        bus.wr_addr[1] = a1;
        bus.wr_data[0] = d0;
        bus.wr_data[1] = d1;

        pos  = (nv * 800 + nh + 2) % 420000;
        hl   = pos % 800;
        vl   = pos / 800;
        disp = (hl % 2 == 0) && (hl < 640) && (vl < 480);

        if (fv[1]) cur = fval[1];
        e.pix      = cur;
        e.chk_pix  = chk_pix_en;
        e.pristine = pristine;
        e.t4       = t4;
        e.hc       = nh;
        e.vc       = nv;
        fv[1]   = fv[0];
        fval[1] = fval[0];
        fv[0]   = (hl % 2 == 0);
        fval[0] = disp ? shadow[(vl / 2) * 320 + hl / 2] : 8'h00;

        g = 2'b00;
        if (!r && !disp) begin
            if (v == 2'b11) begin
                g    = (turn == 0) ? 2'b01 : 2'b10;
                turn = 1 - turn;
            end else begin
                g = v;
            end
        end
        e.rdy  = g;
        e.fs   = !r && (nh == 0) && (nv == 0);
        e.we   = 1'b0;
        e.addr = '0;
        if (g != 2'b00) begin
            e.addr = g[1] ? a1 : a0;
            wa     = int'(e.addr);
            if (wa < FB_SIZE) begin
                e.we       = 1'b1;
                shadow[wa] = g[1] ? d1 : d0;
            end
        end else if (!r && disp) begin
            e.addr = ADDR_W'((vl / 2) * 320 + hl / 2);
        end
        if (r) begin
            cur   = '0;
            fv[0] = 1'b0;
            fv[1] = 1'b0;
            turn  = 0;
        end
        q.push_back(e);

        nh++;
        if (nh == 800) begin
            nh = 0;
            nv = (nv + 1) % 525;
        end
    endtask

    // mode: 0 idle, 1 requester 0 only, 2 both requesters, 3 random valid.
    task automatic run(input int h0, input int v0, input int n, input int mode);
        nh = h0;
        nv = v0;
        repeat (n) begin
            logic [1:0]        v;
            logic [ADDR_W-1:0] a0, a1;
            logic [7:0]        d0, d1;
            a0 = rand_addr();
            a1 = rand_addr();
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            case (mode)
                0:       v = 2'b00;
                1:       v = 2'b01;
                2:       v = 2'b11;
                default: v = 2'($urandom);
            endcase
            drive_cycle(1'b0, v, a0, a1, d0, d1);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge vgaclk);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.chk_pix) check("pix_rgb", pix_rgb, e.pix);
                check("wr_ready", bus.wr_ready, e.rdy);
                check("ram_we", bus.ram_we, e.we);
                check("ram_addr", bus.ram_addr, e.addr);
                check("frame_start", frame_start, e.fs);
                if (e.pristine && e.hc == 0 && e.vc == 0)   check("pix_fill_0_0", pix_rgb, 8'h00);
                if (e.pristine && e.hc == 2 && e.vc == 0)   check("pix_fill_2_0", pix_rgb, 8'h01);
                if (e.pristine && e.hc == 639 && e.vc == 479) check("pix_fill_639_479", pix_rgb, 8'hFF);
                if (e.t4 && e.vc == 0 && e.hc < 2)          check("pix_e3_written", pix_rgb, 8'hE3);
            end
        end
    end

    initial begin
        for (int i = 0; i < FB_SIZE; i++) shadow[i] = 8'(i);
        turn       = 0;
        cur        = '0;
        fv[0]      = 1'b0;
        fv[1]      = 1'b0;
        fval[0]    = '0;
        fval[1]    = '0;
        pristine   = 1'b1;
        t4         = 1'b0;
        chk_pix_en = 1'b0;

        nh = 780;
        nv = 524;
        repeat (4) drive_cycle(1'b1, 2'b00, '0, '0, '0, '0);
        chk_pix_en = 1'b1;

        run(790, 524, 1620, 0);
        run(620, 479, 40, 0);
        pristine = 1'b0;

        run(0, 10, 200, 1);
        run(650, 10, 6, 2);
        run(656, 10, 40, 3);

        nh = 100;
        nv = 500;
        drive_cycle(1'b0, 2'b01, '0, '0, 8'hE3, 8'h00);
        nh = 200;
        nv = 510;
        drive_cycle(1'b0, 2'b10, '0, ADDR_W'(FB_SIZE), 8'h00, 8'h5A);
        t4 = 1'b1;
        run(790, 524, 20, 0);
        t4 = 1'b0;

        run(280, 100, 19, 2);
        drive_cycle(1'b0, (turn == 0) ? 2'b11 : 2'b00, rand_addr(), rand_addr(), 8'h11, 8'h22);
        drive_cycle(1'b1, 2'b11, rand_addr(), rand_addr(), 8'h33, 8'h44);
        run(301, 100, 1000, 2);

        for (int k = 0; k < 14; k++) begin
            run(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1500, 3);
        end

        @(negedge vgaclk);
        #1;
        check("queue_drained", q.size(), 0);
        check("ram_76800_untouched", ram[76800], 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
